// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if
//   Command channel between the host-side command decoder and the LED
//   sequencing controller. A command is accepted on a rising clk edge where
//   cmd_valid and cmd_ready are both high.
//
//   cmd_valid  decoder -> ctrl  command present
//   cmd_ready  ctrl -> decoder  controller can take a command this cycle
//   cmd_mode   decoder -> ctrl  0 off, 1 rotate-left, 2 rotate-right, 3 blink
//   cmd_speed  decoder -> ctrl  rate select (used only with LED_SEQ_SPEED_EN)
interface led_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [1:0] cmd_speed;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_speed,
    output cmd_ready
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
//   Sequencing controller for the 8-bit LED bank. Takes pattern commands over
//   a valid/ready channel and steps the LEDs (off, rotate-left, rotate-right,
//   blink) on a timebase of div_max+1 clk cycles.
//
//   Optional feature macro: LED_SEQ_SPEED_EN. When defined, cmd_speed is
//   latched on accept and div_max = TICK_MAX >> speed. Otherwise cmd_speed is
//   ignored and div_max = TICK_MAX.
//
//   Ports
//     clk    system clock
//     rstn   asynchronous active-low reset
//     cmd    command channel (slave side)
//     hold   freezes step counter and pattern while high (RUN only)
//     step   one-cycle pulse on every pattern advance
//     busy   high while loading or running a pattern
//     led    LED drive, 1 = on
module led_seq_ctrl #(
  parameter logic [24:0] TICK_MAX = 25'd24_999_999
) (
  input  logic           clk,
  input  logic           rstn,
  led_seq_ctrl_if.slave  cmd,
  input  logic           hold,
  output logic           step,
  output logic           busy,
  output logic [7:0]     led
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [24:0] cnt_q, cnt_d;
  logic [24:0] div_max_s;
  logic [7:0]  led_q, led_d;
  logic        step_q, step_d;
  logic        ready_s;
  logic        accept_s;

  // Starting pattern shown on the edge that leaves LOAD.
  function automatic logic [7:0] init_pattern(input logic [1:0] mode);
    logic [7:0] pat;
    case (mode)
      2'd1:    pat = 8'h01;
      2'd2:    pat = 8'h80;
      2'd3:    pat = 8'hFF;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  // Pattern after one step in the given mode.
  function automatic logic [7:0] advance(input logic [1:0] mode, input logic [7:0] cur);
    logic [7:0] nxt;
    case (mode)
      2'd1:    nxt = {cur[6:0], cur[7]};
      2'd2:    nxt = {cur[0], cur[7:1]};
      2'd3:    nxt = ~cur;
      default: nxt = 8'h00;
    endcase
    return nxt;
  endfunction

  assign ready_s       = (state_q != ST_LOAD);
  assign accept_s      = cmd.cmd_valid && ready_s;
  assign cmd.cmd_ready = ready_s;
  assign busy          = (state_q != ST_IDLE);
  assign step          = step_q;
  assign led           = led_q;

`ifdef LED_SEQ_SPEED_EN
  logic [1:0] speed_q, speed_d;

  // Speed select captured with the command; only changes on accept.
  always_comb begin
    speed_d = speed_q;
    if (accept_s) begin
      speed_d = cmd.cmd_speed;
    end else begin
      speed_d = speed_q;
    end
  end

  // Speed register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      speed_q <= 2'd0;
    end else begin
      speed_q <= speed_d;
    end
  end

  assign div_max_s = TICK_MAX >> speed_q;
`else
  logic speed_unused_s;
  assign speed_unused_s = ^cmd.cmd_speed;
  assign div_max_s      = TICK_MAX;
`endif

  // Next-state and datapath decode. A command accepted in RUN takes priority
  // over a wrap in the same cycle, so no step is issued then.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    step_d  = 1'b0;
    if (accept_s) begin
      mode_d = cmd.cmd_mode;
    end else begin
      mode_d = mode_q;
    end
    case (state_q)
      ST_IDLE: begin
        cnt_d = 25'd0;
        led_d = 8'h00;
        if (accept_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d = 25'd0;
        led_d = init_pattern(mode_q);
        if (mode_q != 2'd0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          state_d = ST_LOAD;
        end else if (hold) begin
          state_d = ST_RUN;
        end else if (cnt_q == div_max_s) begin
          cnt_d  = 25'd0;
          step_d = 1'b1;
          led_d  = advance(mode_q, led_q);
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 25'd0;
        led_d   = 8'h00;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      cnt_q   <= 25'd0;
      led_q   <= 8'h00;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl
//   Scoreboard bench for led_seq_ctrl with TICK_MAX = 7. A behavioural model
//   (pending command flag, active flag, cycles-into-period, step count) predicts
//   the outputs each cycle and queues them; a monitor on the falling edge pops
//   and compares.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       hold = 1'b0;
  logic       step;
  logic       busy;
  logic [7:0] led;

  led_seq_ctrl_if cmd_if();

  led_seq_ctrl #(.TICK_MAX(25'd7)) dut (
    .clk  (clk),
    .rstn (rstn),
    .cmd  (cmd_if),
    .hold (hold),
    .step (step),
    .busy (busy),
    .led  (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic       step;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state
  bit m_loading;
  bit m_active;
  bit m_step;
  int m_lmode, m_lspeed, m_mode, m_speed, m_phase, m_steps;

  function automatic int period(input int spd);
`ifdef LED_SEQ_SPEED_EN
    return (7 >> spd) + 1;
`else
    return 8 + 0 * spd;
`endif
  endfunction

  function automatic logic [7:0] pattern(input int mode, input int steps);
    logic [7:0] one, top;
    one = 8'h01;
    top = 8'h80;
    case (mode)
      1:       return one << (steps % 8);
      2:       return top >> (steps % 8);
      3:       return ((steps % 2) == 1) ? 8'h00 : 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_loading = 1'b0;
    m_active  = 1'b0;
    m_step    = 1'b0;
    m_lmode   = 0;
    m_lspeed  = 0;
    m_mode    = 0;
    m_speed   = 0;
    m_phase   = 0;
    m_steps   = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held over it.
  task automatic model_edge();
    m_step = 1'b0;
    if (m_loading) begin
      m_loading = 1'b0;
      m_active  = (m_lmode != 0);
      m_mode    = m_lmode;
      m_speed   = m_lspeed;
      m_phase   = 0;
      m_steps   = 0;
    end else if (cmd_if.cmd_valid) begin
      m_loading = 1'b1;
      m_lmode   = int'(cmd_if.cmd_mode);
      m_lspeed  = int'(cmd_if.cmd_speed);
    end else if (m_active && !hold) begin
      m_phase++;
      if (m_phase == period(m_speed)) begin
        m_phase = 0;
        m_steps++;
        m_step  = 1'b1;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.led   = m_active ? pattern(m_mode, m_steps) : 8'h00;
    e.step  = m_step;
    e.busy  = m_loading || m_active;
    e.ready = !m_loading;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then apply the inputs for the following cycle.
  task automatic cycle(input bit v, input logic [1:0] md, input logic [1:0] sp,
                       input bit h, input bit r);
    @(posedge clk);
    #1;
    if (rstn) model_edge();
    cmd_if.cmd_valid = v;
    cmd_if.cmd_mode  = md;
    cmd_if.cmd_speed = sp;
    hold             = h;
    rstn             = r;
    if (!r) model_reset();
    push_expect();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs against queued predictions mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("led",       led,                     e.led);
      chk("step",      {7'd0, step},            {7'd0, e.step});
      chk("busy",      {7'd0, busy},            {7'd0, e.busy});
      chk("cmd_ready", {7'd0, cmd_if.cmd_ready}, {7'd0, e.ready});
    end
  end

  initial begin
    int n;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'd0;
    cmd_if.cmd_speed = 2'd0;
    model_reset();

    // Reset then idle
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    idle_cycles(20);

    // Rotate-left through a full wrap
    cycle(1'b1, 2'd1, 2'd0, 1'b0, 1'b1);
    idle_cycles(70);

    // Blink, then retarget to rotate-right on a wrap cycle
    cycle(1'b1, 2'd3, 2'd0, 1'b0, 1'b1);
    idle_cycles(20);
    n = 0;
    while (!(m_active && !m_loading && m_phase == period(m_speed) - 1) && n < 20) begin
      idle_cycles(1);
      n++;
    end
    cycle(1'b1, 2'd2, 2'd0, 1'b0, 1'b1);
    idle_cycles(20);

    // Hold for 5 cycles with the counter at 3
    n = 0;
    while (!(m_active && !m_loading && m_phase == 3) && n < 20) begin
      idle_cycles(1);
      n++;
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    idle_cycles(20);

    // Speed select 2
    cycle(1'b1, 2'd1, 2'd2, 1'b0, 1'b1);
    idle_cycles(20);

    // Async reset while led = 04
    cycle(1'b1, 2'd1, 2'd0, 1'b0, 1'b1);
    n = 0;
    while (!(m_active && m_steps == 2 && m_phase == 4) && n < 60) begin
      idle_cycles(1);
      n++;
    end
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    idle_cycles(12);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 10) == 0, 2'($urandom), 2'($urandom),
            ($urandom % 6) == 0, ($urandom % 150) != 0);
    end
    idle_cycles(3);

    @(negedge clk);
    #1;
    chk("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the 8-bit board LED bank in the remote-lab FPGA design. It accepts pattern commands from the host-side command decoder over a valid/ready handshake and owns the LED step timebase. It drives `led[7:0]` with off, rotate-left, rotate-right or blink patterns at a selectable step rate. It sits between the command decoder and the LED pins, taking over from the fixed free-running rotator.

## Interface
- `TICK_MAX`, 25'd24_999_999: base step period minus one, in `clk` cycles. At 50 MHz this gives 0.5 s. Must fit in 25 bits.
- `clk`  input  1  system clock, single clock domain.
- `rstn`  input  1  reset, asynchronous, active-low.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  controller can accept a command this cycle.
- `cmd_mode`  input  2  0 = off, 1 = rotate-left, 2 = rotate-right, 3 = blink.
- `cmd_speed`  input  2  rate select. Only used when `LED_SEQ_SPEED_EN` is defined.
- `hold`  input  1  freezes the step counter and the pattern while high.
- `step`  output  1  one-cycle pulse on every pattern advance.
- `busy`  output  1  high in LOAD and RUN.
- `led`  output  8  LED drive, 1 = on.

## Operation
- State machine states: IDLE, LOAD, RUN.
  - IDLE to LOAD on a command accept.
  - LOAD to RUN when the latched mode is not 0.
  - LOAD to IDLE when the latched mode is 0.
  - RUN to LOAD on a command accept.
- Command accept is `cmd_valid && cmd_ready` at a rising `clk` edge. On accept, `cmd_mode` and `cmd_speed` are latched.
- `cmd_ready` = 1 in IDLE and RUN, 0 in LOAD. It is decoded combinationally from state.
- LOAD lasts exactly 1 cycle. On the edge leaving LOAD:
  - the step counter is cleared to 0;
  - `led` is loaded with the initial pattern: mode 1 8'h01, mode 2 8'h80, mode 3 8'hFF, mode 0 8'h00.
- RUN:
  - The step counter increments each cycle unless `hold` = 1.
  - When the counter equals `div_max` and `hold` = 0, the counter wraps to 0, `step` pulses and the pattern advances.
  - Mode 1 advance: `{led[6:0],led[7]}`.
  - Mode 2 advance: `{led[0],led[7:1]}`.
  - Mode 3 advance: `~led`.
- IDLE: `led` holds 8'h00, the counter holds 0 and `step` = 0.
- `busy` = (state != IDLE).
- Arithmetic:
  - The counter is 25 bits and never exceeds `div_max`.
  - `div_max = TICK_MAX >> speed`, with a logical shift; speed 0..3.
  - The comparison is equality only.

## Timing
- Reset (async, `rstn` low):
  - state IDLE, `led` 8'h00, counter 0, `step` 0, `busy` 0, `cmd_ready` 1;
  - latched mode 0, latched speed 0.
- Reset release: takes effect at the first `clk` edge after `rstn` rises. Commands are ignored while `rstn` is low.
- Command latency:
  - accept at edge N;
  - state LOAD during cycle N..N+1;
  - new `led` pattern visible after edge N+1;
  - first `step` at edge N+1+div_max+1.
- Step period in RUN with no hold: exactly div_max+1 cycles.
- Simultaneous accept and wrap in the same RUN cycle: the command wins. No `step` pulse and no pattern advance occur; LOAD follows.
- `hold` during LOAD is ignored; LOAD always completes in 1 cycle.
- `hold` released: counting resumes from the held value. Frozen cycles do not count toward the period.
- A mode-0 command from RUN goes through LOAD, then IDLE, with `led` = 8'h00 after edge N+1.
- Reset asserted mid-RUN or mid-LOAD: all outputs take their reset values immediately. A pending or latched command is discarded.

## Configuration
- `LED_SEQ_SPEED_EN` defined:
  - `cmd_speed` is latched on accept;
  - `div_max = TICK_MAX >> cmd_speed`.
- `LED_SEQ_SPEED_EN` undefined:
  - `cmd_speed` is ignored and no speed register exists;
  - `div_max = TICK_MAX` always.

## Test plan
All scenarios use `TICK_MAX` = 7.
- Reset then idle:
  - stimulus: `rstn` low 3 cycles, then high 20 cycles, no commands;
  - response: `led` = 8'h00, `cmd_ready` = 1, `busy` = 0, `step` never pulses.
- Rotate-left sequencing and wrap:
  - stimulus: mode 1 accepted at edge N;
  - response: `led` = 8'h01 after N+1; `step` pulses every 8 cycles; `led` reaches 8'h80 after 7 steps and 8'h01 after the 8th.
- Blink, then retarget mid-run:
  - stimulus: mode 3 accepted, `led` toggles FF/00 each 8 cycles; then mode 2 is accepted on the same cycle as a wrap;
  - response: no `step` that cycle; `cmd_ready` = 0 for one cycle; `led` = 8'h80 after the next edge.
- Hold:
  - stimulus: rotate-right, `hold` high for 5 cycles at counter = 3;
  - response: `led` and counter frozen; next `step` arrives 5 cycles later than nominal.
- Speed, with `LED_SEQ_SPEED_EN` defined:
  - stimulus: mode 1 with speed 2 (div_max 1);
  - response: `step` every 2 cycles.
  - With the macro undefined, the same stimulus gives `step` every 8 cycles.
- Async reset mid-run:
  - stimulus: `rstn` dropped between edges while `led` = 8'h04;
  - response: `led` = 8'h00, `busy` = 0 before the next edge; mode-0 behaviour (IDLE) after release.
